loadable_memory: RTL and testbench
==================================

Name: loadable_memory

Overview:
- Parametrised single-clock synchronous RAM for program/data storage, with a CPU access port and a host loader port.
- Loader is a byte/word stream with valid/ready, used by the host to upload a program image at runtime.
- An optional post-reset clear sequencer replaces elaboration-time initialisation.
- Sits between the CPU bus decoder and the host upload interface; the CPU is held off via busy while clearing or loading.

Parameters:
- ADDR_WIDTH, 8, address bits; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, word width of both ports.
- CLEAR_ON_RESET, 1, 1 = sequential fill after reset; 0 = go straight to IDLE.
- FILL_VALUE, 0, word written by the clear sequencer.
- PROTECT_BASE, 2**ADDR_WIDTH-16, first protected address (used only with the optional feature).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_data_in  in  DATA_WIDTH  CPU write data.
- cpu_rd  in  1  read strobe.
- cpu_we  in  1  write strobe.
- cpu_data_out  out  DATA_WIDTH  registered read data.
- cpu_rd_valid  out  1  high the cycle after an accepted read.
- busy  out  1  high in CLEAR or LOAD; CPU accesses ignored.
- ld_start  in  1  pulse: enter LOAD, pointer <= ld_addr.
- ld_addr  in  ADDR_WIDTH  load base address.
- ld_data  in  DATA_WIDTH  load word.
- ld_valid  in  1  load word valid.
- ld_ready  out  1  loader accepts a word.
- ld_end  in  1  pulse: leave LOAD.
- ld_count  out  ADDR_WIDTH+1  words written in current/last load.

Behaviour:
- Reset (async assert, sync-released by the system): cpu_data_out=0, cpu_rd_valid=0, ld_ready=0, ld_count=0, clear pointer=0.
  - State after reset: CLEAR if CLEAR_ON_RESET else IDLE. busy=1 in CLEAR.
- RAM contents are not reset; only the CLEAR state initialises them.
- CLEAR: writes FILL_VALUE to ram[ptr] each cycle, ptr++.
  - After writing address 2**ADDR_WIDTH-1 → IDLE (exactly 2**ADDR_WIDTH cycles).
  - Reset mid-clear restarts from 0.
  - ld_start is ignored in CLEAR.
- IDLE: busy=0.
  - cpu_we writes ram[cpu_addr].
  - cpu_rd: cpu_data_out <= ram[cpu_addr] next edge; cpu_rd_valid pulses for 1 cycle.
  - rd and we to the same address in the same cycle: read returns old data (read-before-write).
  - cpu_data_out holds its value when no read occurs.
  - ld_start → LOAD, ptr <= ld_addr, ld_count <= 0. CPU strobes in the same cycle as ld_start are ignored.
- LOAD: busy=1, ld_ready=1.
  - Transfer on ld_valid&&ld_ready: ram[ptr] <= ld_data, ptr++ (wraps mod depth), ld_count++ (saturates at 2**ADDR_WIDTH).
  - ld_end → IDLE next cycle, ld_ready=0; a word transferred in the same cycle as ld_end is written.
  - ld_start in LOAD re-bases ptr and zeroes ld_count.
  - CPU rd/we are ignored; cpu_rd_valid stays 0.
- ld_count holds its value after LOAD until the next ld_start.

Optional Feature:
- Macro: LOADABLE_MEMORY_WPROT_EN.
- Defined: CPU writes to addresses >= PROTECT_BASE are silently dropped (ROM region, e.g. boot monitor). Loader and CLEAR writes are still allowed.
  - Adds output wprot_hit (1 bit, reset 0): pulses 1 cycle after a dropped write.
- Undefined: all CPU writes land; no wprot_hit port.

Decomposition:
- Shared package mem_pkg:
  - typedef enum mem_state_e {MS_CLEAR, MS_IDLE, MS_LOAD}.
  - Localparam helper for depth.
- One sub-module: mem_array (pure synchronous RAM, one write port, one read port, read-before-write).
  - Top level owns the FSM and the write-source mux (CLEAR / loader / CPU).

Test Plan:
- Reset with CLEAR_ON_RESET=1, ADDR_WIDTH=4, FILL_VALUE=8'hFF → busy=1 for 16 cycles then 0; reads of 0..15 return FF.
- ld_start with ld_addr=4'hE, stream 8'h11,22,33, ld_end → busy=1 throughout, ld_count=3; CPU reads of E,F,0 return 11,22,33 (wrap).
- In IDLE, cpu_we to addr 5 with 8'hA5 and cpu_rd of addr 5 in the same cycle → cpu_data_out = old value; next read returns A5; cpu_rd_valid is a 1-cycle pulse each time.
- During LOAD, cpu_we to addr 2 with 8'h77 → ram[2] unchanged; cpu_rd_valid stays 0.
- reset_n pulsed low at clear cycle 7 → restarts; busy is high for a full 16 cycles after release.
- WPROT_EN, PROTECT_BASE=12: cpu_we to addr 13 with 8'h55 → ram[13] unchanged, wprot_hit pulses; loader write to 13 succeeds.

Source files
------------

// File: rtl/loadable_memory_pkg.sv
// mem_pkg: shared FSM state type and depth helper for loadable_memory.
`default_nettype none

package mem_pkg;

  typedef enum logic [1:0] {
    MS_CLEAR = 2'd0,
    MS_IDLE  = 2'd1,
    MS_LOAD  = 2'd2
  } mem_state_e;

  localparam int MEM_STATE_W = 2;

  function automatic int mem_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/loadable_memory_mem_array.sv
// mem_array: single-clock RAM, one write and one registered read port (read-before-write).
`default_nettype none

module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = mem_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage is deliberately left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/loadable_memory.sv
// loadable_memory: CPU-port RAM with host loader stream and post-reset clear sequencer.
// Optional CPU write protection above PROTECT_BASE: `define LOADABLE_MEMORY_WPROT_EN.
`default_nettype none

module loadable_memory
  import mem_pkg::*;
#(
  parameter int                   ADDR_WIDTH     = 8,
  parameter int                   DATA_WIDTH     = 8,
  parameter int                   CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE    = '0,
  parameter int                   PROTECT_BASE   = 2**ADDR_WIDTH - 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data_in,
  input  logic                  cpu_rd,
  input  logic                  cpu_we,
  output logic [DATA_WIDTH-1:0] cpu_data_out,
  output logic                  cpu_rd_valid,
  output logic                  busy,
  input  logic                  ld_start,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic                  ld_end,
`ifdef LOADABLE_MEMORY_WPROT_EN
  output logic                  wprot_hit,
`endif
  output logic [ADDR_WIDTH:0]   ld_count
);

  localparam int                DEPTH       = mem_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] CNT_MAX   = DEPTH[ADDR_WIDTH:0];
  localparam mem_state_e        RESET_STATE = (CLEAR_ON_RESET != 0) ? MS_CLEAR : MS_IDLE;

  mem_state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
  logic                    rd_valid_q;

  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   ram_waddr;
  logic [DATA_WIDTH-1:0]   ram_wdata;
  logic                    ram_re;

`ifdef LOADABLE_MEMORY_WPROT_EN
  localparam logic [ADDR_WIDTH:0] PROT_BASE_C = PROTECT_BASE[ADDR_WIDTH:0];
  logic cpu_prot;
  logic hit_d;
  logic wprot_q;
  assign cpu_prot = ({1'b0, cpu_addr} >= PROT_BASE_C);
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    ram_we    = 1'b0;
    ram_waddr = ptr_q;
    ram_wdata = FILL_VALUE;
    ram_re    = 1'b0;
`ifdef LOADABLE_MEMORY_WPROT_EN
    hit_d     = 1'b0;
`endif
    case (state_q)
      MS_CLEAR: begin
        ram_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = MS_IDLE;
        end
      end
      MS_IDLE: begin
        // A load request owns the cycle; coincident CPU strobes are dropped.
        if (ld_start) begin
          state_d = MS_LOAD;
          ptr_d   = ld_addr;
          cnt_d   = '0;
        end else begin
          ram_re    = cpu_rd;
          ram_waddr = cpu_addr;
          ram_wdata = cpu_data_in;
`ifdef LOADABLE_MEMORY_WPROT_EN
          hit_d  = cpu_we && cpu_prot;
          ram_we = cpu_we && !cpu_prot;
`else
          ram_we = cpu_we;
`endif
        end
      end
      MS_LOAD: begin
        ram_wdata = ld_data;
        if (ld_valid) begin
          ram_we = 1'b1;
          ptr_d  = ptr_q + 1'b1;
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (ld_start) begin
          ptr_d = ld_addr;
          cnt_d = '0;
        end
        if (ld_end) begin
          state_d = MS_IDLE;
        end
      end
      default: begin
        state_d = MS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RESET_STATE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= ram_re;
    end
  end

`ifdef LOADABLE_MEMORY_WPROT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wprot_q <= 1'b0;
    end else begin
      wprot_q <= hit_d;
    end
  end
  assign wprot_hit = wprot_q;
`endif

  mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem_array (
    .clk    (clk),
    .reset_n(reset_n),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .re_i   (ram_re),
    .raddr_i(cpu_addr),
    .rdata_o(cpu_data_out)
  );

  assign cpu_rd_valid = rd_valid_q;
  assign busy         = (state_q != MS_IDLE);
  assign ld_ready     = (state_q == MS_LOAD);
  assign ld_count     = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_loadable_memory.sv
// tb_loadable_memory: directed + random checks of loadable_memory against an array model.
`default_nettype none

module tb_loadable_memory;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int PB    = 12;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data_in;
  logic          cpu_rd;
  logic          cpu_we;
  logic [DW-1:0] cpu_data_out;
  logic          cpu_rd_valid;
  logic          busy;
  logic          ld_start;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          ld_valid;
  logic          ld_ready;
  logic          ld_end;
  logic          wprot_hit;
  logic [AW:0]   ld_count;

  always #5 clk = ~clk;

  loadable_memory #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .CLEAR_ON_RESET(1),
    .FILL_VALUE    (8'hFF),
    .PROTECT_BASE  (PB)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cpu_addr    (cpu_addr),
    .cpu_data_in (cpu_data_in),
    .cpu_rd      (cpu_rd),
    .cpu_we      (cpu_we),
    .cpu_data_out(cpu_data_out),
    .cpu_rd_valid(cpu_rd_valid),
    .busy        (busy),
    .ld_start    (ld_start),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_end      (ld_end),
`ifdef LOADABLE_MEMORY_WPROT_EN
    .wprot_hit   (wprot_hit),
`endif
    .ld_count    (ld_count)
  );

`ifndef LOADABLE_MEMORY_WPROT_EN
  assign wprot_hit = 1'b0;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  model [DEPTH];
  int          m_ptr;
  int          m_cnt;
  logic [7:0]  m_out;
  bit          m_loading;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit prot(input int a);
`ifdef LOADABLE_MEMORY_WPROT_EN
    return a >= PB;
`else
    return 1'b0;
`endif
  endfunction

  task automatic cpu_op(input bit rd, input bit we, input int addr, input logic [7:0] data);
    bit exp_valid;
    bit exp_hit;
    logic [AW-1:0] a;
    a           = addr[AW-1:0];
    cpu_rd      = rd;
    cpu_we      = we;
    cpu_addr    = a;
    cpu_data_in = data;
    exp_valid   = 1'b0;
    exp_hit     = 1'b0;
    if (!m_loading) begin
      if (rd) begin
        m_out     = model[addr];
        exp_valid = 1'b1;
      end
      if (we) begin
        if (prot(addr)) exp_hit = 1'b1;
        else            model[addr] = data;
      end
    end
    tick();
    cpu_rd = 1'b0;
    cpu_we = 1'b0;
    check("rd_valid", cpu_rd_valid, exp_valid);
    check("data_out", cpu_data_out, m_out);
`ifdef LOADABLE_MEMORY_WPROT_EN
    check("wprot_hit", wprot_hit, exp_hit);
`endif
  endtask

  task automatic idle_tick();
    tick();
    check("idle_rd_valid", cpu_rd_valid, 0);
    check("idle_data_hold", cpu_data_out, m_out);
    check("idle_ld_count", ld_count, m_cnt);
  endtask

  task automatic ld_begin(input int addr);
    ld_start = 1'b1;
    ld_addr  = addr[AW-1:0];
    tick();
    ld_start  = 1'b0;
    m_ptr     = addr;
    m_cnt     = 0;
    m_loading = 1'b1;
    check("ld_busy", busy, 1);
    check("ld_ready", ld_ready, 1);
    check("ld_count_zero", ld_count, 0);
  endtask

  task automatic ld_word(input bit valid, input logic [7:0] data);
    ld_valid = valid;
    ld_data  = data;
    tick();
    ld_valid = 1'b0;
    if (valid) begin
      model[m_ptr] = data;
      m_ptr        = (m_ptr + 1) % DEPTH;
      m_cnt        = (m_cnt < DEPTH) ? m_cnt + 1 : DEPTH;
    end
    check("ld_count", ld_count, m_cnt);
    check("ld_busy_hold", busy, 1);
  endtask

  task automatic ld_finish(input bit with_word, input logic [7:0] data);
    ld_end   = 1'b1;
    ld_valid = with_word;
    ld_data  = data;
    tick();
    ld_end   = 1'b0;
    ld_valid = 1'b0;
    if (with_word) begin
      model[m_ptr] = data;
      m_ptr        = (m_ptr + 1) % DEPTH;
      m_cnt        = (m_cnt < DEPTH) ? m_cnt + 1 : DEPTH;
    end
    m_loading = 1'b0;
    check("end_busy", busy, 0);
    check("end_ld_ready", ld_ready, 0);
    check("end_ld_count", ld_count, m_cnt);
  endtask

  // Asserts reset, checks reset outputs, then counts busy cycles of the clear.
  // abort_after > 0 stops counting early so a mid-clear reset can follow.
  task automatic reset_and_clear(input int abort_after);
    int n;
    reset_n = 1'b0;
    #2;
    check("rst_data_out", cpu_data_out, 0);
    check("rst_rd_valid", cpu_rd_valid, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_ld_count", ld_count, 0);
    check("rst_busy", busy, 1);
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    m_out     = 8'h00;
    m_cnt     = 0;
    m_loading = 1'b0;
    if (abort_after > 0) begin
      for (int i = 0; i < abort_after; i++) tick();
      check("mid_clear_busy", busy, 1);
    end else begin
      n = 0;
      while (busy === 1'b1 && n < 40) begin
        tick();
        n++;
      end
      check("clear_cycles", n, DEPTH);
      for (int i = 0; i < DEPTH; i++) model[i] = 8'hFF;
    end
  endtask

  initial begin
    cpu_addr    = '0;
    cpu_data_in = '0;
    cpu_rd      = 1'b0;
    cpu_we      = 1'b0;
    ld_start    = 1'b0;
    ld_addr     = '0;
    ld_data     = '0;
    ld_valid    = 1'b0;
    ld_end      = 1'b0;
    m_ptr       = 0;

    // Power-on reset, full clear, every word reads back FILL_VALUE.
    reset_and_clear(0);
    for (int i = 0; i < DEPTH; i++) cpu_op(1'b1, 1'b0, i, 8'h00);
    check("fill_last", cpu_data_out, 8'hFF);

    // Load wrapping past the top of memory.
    ld_begin(14);
    ld_word(1'b1, 8'h11);
    ld_word(1'b0, 8'hEE);
    ld_word(1'b1, 8'h22);
    ld_word(1'b1, 8'h33);
    ld_finish(1'b0, 8'h00);
    check("load3_count", ld_count, 3);
    cpu_op(1'b1, 1'b0, 14, 8'h00);
    check("wrap_E", cpu_data_out, 8'h11);
    cpu_op(1'b1, 1'b0, 15, 8'h00);
    check("wrap_F", cpu_data_out, 8'h22);
    cpu_op(1'b1, 1'b0, 0, 8'h00);
    check("wrap_0", cpu_data_out, 8'h33);

    // Same-cycle read and write returns old data; rd_valid is a single pulse.
    cpu_op(1'b1, 1'b1, 5, 8'hA5);
    check("rbw_old", cpu_data_out, 8'hFF);
    idle_tick();
    cpu_op(1'b1, 1'b0, 5, 8'h00);
    check("rbw_new", cpu_data_out, 8'hA5);
    idle_tick();

    // CPU strobes during LOAD are ignored; word with ld_end is still written.
    ld_begin(8);
    cpu_op(1'b0, 1'b1, 2, 8'h77);
    cpu_op(1'b1, 1'b1, 2, 8'h78);
    ld_word(1'b1, 8'h5A);
    ld_finish(1'b1, 8'h6B);
    check("load_end_word_count", ld_count, 2);
    cpu_op(1'b1, 1'b0, 2, 8'h00);
    check("load_cpu_blocked", cpu_data_out, 8'hFF);
    cpu_op(1'b1, 1'b0, 9, 8'h00);
    check("end_word_written", cpu_data_out, 8'h6B);

    // Protected region: CPU write dropped only when protection is built in.
    cpu_op(1'b0, 1'b1, 13, 8'h55);
    cpu_op(1'b1, 1'b0, 13, 8'h00);
    ld_begin(13);
    ld_word(1'b1, 8'h55);
    ld_finish(1'b0, 8'h00);
    cpu_op(1'b1, 1'b0, 13, 8'h00);
    check("loader_prot_write", cpu_data_out, 8'h55);

    // Count saturates at depth; re-base mid-load zeroes the count.
    ld_begin(3);
    for (int i = 0; i < 20; i++) ld_word(1'b1, 8'($urandom));
    check("count_saturated", ld_count, DEPTH);
    ld_begin(6);
    ld_word(1'b1, 8'hC3);
    ld_finish(1'b0, 8'h00);
    for (int i = 0; i < 3; i++) idle_tick();
    for (int i = 0; i < DEPTH; i++) cpu_op(1'b1, 1'b0, i, 8'h00);

    // Random mix of CPU traffic and load bursts.
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 9) < 8) begin
        cpu_op(1'($urandom), 1'($urandom), $urandom_range(0, DEPTH - 1), 8'($urandom));
      end else begin
        ld_begin($urandom_range(0, DEPTH - 1));
        for (int k = 0; k < $urandom_range(0, 6); k++) begin
          if ($urandom_range(0, 3) == 0)
            cpu_op(1'($urandom), 1'($urandom), $urandom_range(0, DEPTH - 1), 8'($urandom));
          else if ($urandom_range(0, 9) == 0)
            ld_begin($urandom_range(0, DEPTH - 1));
          else
            ld_word(1'($urandom_range(0, 3) != 0), 8'($urandom));
        end
        ld_finish(1'($urandom), 8'($urandom));
      end
    end
    for (int i = 0; i < DEPTH; i++) cpu_op(1'b1, 1'b0, i, 8'h00);

    // Reset at clear cycle 7 restarts the full clear.
    reset_and_clear(7);
    reset_and_clear(0);
    for (int i = 0; i < 4; i++) cpu_op(1'b1, 1'b0, i * 5, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
